lifo_pop_streamer: RTL and testbench

Downstream drain stage for the 8-bit LIFO. It accepts a frame request (start pulse and length), pops up to that many entries from the LIFO, and presents them in pop order, most recent entry first, on a valid/ready stream with a last-beat marker. A 2-entry output buffer absorbs the LIFO's one-cycle read latency, so the stream sustains one beat per cycle under continuous ready.

---
 rtl/lifo_pop_streamer.sv | 109 ++++++++++
 tb/tb_lifo_pop_streamer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_pop_streamer.sv
// Drains up to len entries from an 8-bit LIFO and streams them most-recent-first
// on a valid/ready port; a 2-entry buffer absorbs the LIFO's one-cycle read latency.
module lifo_pop_streamer #(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              lifo_empty,
   input  logic [DATA_W-1:0] lifo_rdata,
   output logic              lifo_re,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              busy,
   output logic              done,
   output logic              short
);

   typedef enum logic [1:0] {IDLE, POP, FLUSH, DONE} state_t;

   state_t             state, state_nx;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   pop_cnt;
   logic [LEN_W-1:0]   pop_cnt_inc;
   logic               inflight;
   logic               inflight_last;
   logic               short_flag;
   logic [DATA_W-1:0]  buf_data [2];
   logic               buf_last [2];
   logic               wr_ptr;
   logic               rd_ptr;
   logic [1:0]         occ;
   logic [2:0]         pending;
   logic               xfer;

   assign m_valid     = (occ != 2'd0);
   assign m_data      = m_valid ? buf_data[rd_ptr] : '0;
   assign m_last      = m_valid & buf_last[rd_ptr];
   assign xfer        = m_valid & m_ready;
   assign pop_cnt_inc = pop_cnt + {{(LEN_W-1){1'b0}}, 1'b1};
   // Entries still owed to the consumer after this cycle's handshake; counting the
   // departing beat keeps one pop per cycle going under continuous ready.
   assign pending     = {1'b0, occ} + {2'b00, inflight} - {2'b00, xfer};

   assign busy  = (state != IDLE);
   assign done  = (state == DONE);
   assign short = (state == DONE) & short_flag;

   always_comb begin
      state_nx = state;
      lifo_re  = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nx = (len == '0) ? DONE : POP;
         end
         POP: begin
            if (pop_cnt == len_q)  state_nx = FLUSH;
            else if (lifo_empty)   state_nx = FLUSH;
            else                   lifo_re  = (pending < 3'd2);
         end
         FLUSH: begin
            if (pending == 3'd0) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         len_q         <= '0;
         pop_cnt       <= '0;
         short_flag    <= 1'b0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         wr_ptr        <= 1'b0;
         rd_ptr        <= 1'b0;
         occ           <= 2'd0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            len_q      <= len;
            pop_cnt    <= '0;
            short_flag <= 1'b0;
         end
         if (lifo_re) pop_cnt <= pop_cnt_inc;
         if (state == POP && pop_cnt != len_q && lifo_empty) short_flag <= 1'b1;
         inflight      <= lifo_re;
         inflight_last <= (pop_cnt_inc == len_q);
         if (inflight) wr_ptr <= ~wr_ptr;
         if (xfer)     rd_ptr <= ~rd_ptr;
         occ <= pending[1:0];
      end
   end

   // Buffer payload needs no reset: occupancy gates everything read from it.
   always_ff @(posedge clk) begin
      if (inflight) begin
         buf_data[wr_ptr] <= lifo_rdata;
         buf_last[wr_ptr] <= inflight_last;
      end
   end

endmodule

// File: tb/tb_lifo_pop_streamer.sv
// Bench for lifo_pop_streamer: a LIFO environment model, a frame-level reference
// queue checked on every cycle, and directed frames with literal expectations.
module tb_lifo_pop_streamer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [3:0] len = 4'd0;
   logic       lifo_empty;
   logic [7:0] lifo_rdata = 8'd0;
   logic       lifo_re;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready = 1'b1;
   logic       m_last;
   logic       busy;
   logic       done;
   logic       short;

   lifo_pop_streamer #(.DATA_W(8), .LEN_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .lifo_empty(lifo_empty), .lifo_rdata(lifo_rdata), .lifo_re(lifo_re),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .busy(busy), .done(done), .short(short)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   // LIFO environment with registered data_out
   logic [7:0] lifo_mem [16];
   int         lifo_cnt = 0;
   logic       push = 1'b0;
   logic [7:0] push_data = 8'd0;
   assign lifo_empty = (lifo_cnt == 0);

   always @(posedge clk) begin
      if (lifo_re && lifo_cnt > 0) begin
         lifo_rdata <= lifo_mem[lifo_cnt-1];
         lifo_cnt   <= lifo_cnt - 1;
      end else if (push && lifo_cnt < 16) begin
         lifo_mem[lifo_cnt] <= push_data;
         lifo_cnt           <= lifo_cnt + 1;
      end
   end

   // Reference model state: expected beats {last,data} and expected short
   logic [8:0] exp_q [$];
   logic [8:0] got_q [$];
   int         got_cyc [$];
   logic       exp_short = 1'b0;
   logic       done_seen = 1'b0;
   logic       short_seen = 1'b0;
   int         cyc = 0;
   int         pend = 0;
   int         max_pend = 0;
   int         re_cnt = 0;
   int         valid_cnt = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = 8'd0;
   logic       prev_last = 1'b0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      logic [8:0] e;
      if (!rst) begin
         pend       = 0;
         prev_stall = 1'b0;
      end else begin
         chk("re_while_empty", int'(lifo_re & lifo_empty), 0);
         if (prev_stall) begin
            chk("stall_valid", int'(m_valid), 1);
            chk("stall_data", int'(m_data), int'(prev_data));
            chk("stall_last", int'(m_last), int'(prev_last));
         end
         if (m_valid && m_ready) begin
            chk("beat_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("beat_data", int'(m_data), int'(e[7:0]));
               chk("beat_last", int'(m_last), int'(e[8]));
            end
            got_q.push_back({m_last, m_data});
            got_cyc.push_back(cyc);
         end
         pend = pend + int'(lifo_re) - int'(m_valid & m_ready);
         if (pend > max_pend) max_pend = pend;
         chk("outstanding_le2", int'(pend <= 2), 1);
         re_cnt    += int'(lifo_re);
         valid_cnt += int'(m_valid);
         if (done) begin
            chk("done_short", int'(short), int'(exp_short));
            chk("done_drained", exp_q.size(), 0);
            done_seen  = 1'b1;
            short_seen = short;
         end
         prev_stall = m_valid & ~m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
      end
   end

   task automatic push_val(input logic [7:0] d);
      push      = 1'b1;
      push_data = d;
      @(posedge clk); #1;
      push = 1'b0;
   endtask

   // Expected frame: top min(l, depth) entries in pop order, last only on beat l
   task automatic start_frame(input int l);
      int n;
      n = (l < lifo_cnt) ? l : lifo_cnt;
      for (int i = 0; i < n; i++)
         exp_q.push_back({(i + 1 == l), lifo_mem[lifo_cnt-1-i]});
      exp_short = (lifo_cnt < l);
      got_q.delete();
      got_cyc.delete();
      done_seen = 1'b0;
      max_pend  = 0;
      start = 1'b1;
      len   = 4'(l);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int mode);
      logic [3:0] pat;
      int k;
      pat = 4'b1001;
      k = 0;
      while (!done_seen && k < 300) begin
         m_ready = (mode == 0) ? 1'b1 : pat[k % 4];
         @(posedge clk); #1;
         k++;
      end
      m_ready = 1'b1;
      chk("done_timeout", int'(done_seen), 1);
   endtask

   task automatic chk_beats(input string nm, input logic [8:0] ref_beats [$]);
      chk({nm, "_count"}, got_q.size(), ref_beats.size());
      for (int i = 0; i < ref_beats.size() && i < got_q.size(); i++)
         chk({nm, "_beat"}, int'(got_q[i]), int'(ref_beats[i]));
   endtask

   initial begin
      int re0, v0, cnt0;
      logic [8:0] lit [$];

      // Reset state
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_lifo_re", int'(lifo_re), 0);
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_m_last", int'(m_last), 0);
      chk("rst_m_data", int'(m_data), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_short", int'(short), 0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Full frame, continuous ready
      for (int i = 0; i < 8; i++) push_val(8'(i));
      start_frame(8);
      chk("latency_busy", int'(busy), 1);
      chk("latency_re", int'(lifo_re), 1);
      wait_done(0);
      lit = '{9'h007, 9'h006, 9'h005, 9'h004, 9'h003, 9'h002, 9'h001, 9'h100};
      chk_beats("full", lit);
      if (got_cyc.size() == 8) chk("full_back_to_back", got_cyc[7] - got_cyc[0], 7);
      chk("full_short", int'(short_seen), 0);
      chk("full_lifo_empty", int'(lifo_empty), 1);
      @(posedge clk); #1;
      chk("full_busy_low", int'(busy), 0);

      // Truncated frame
      for (int i = 0; i < 4; i++) push_val(8'h10 + 8'(i));
      start_frame(6);
      wait_done(0);
      lit = '{9'h013, 9'h012, 9'h011, 9'h010};
      chk_beats("trunc", lit);
      chk("trunc_short", int'(short_seen), 1);
      @(posedge clk); #1;

      // Stalled consumer
      for (int i = 0; i < 8; i++) push_val(8'(i));
      start_frame(3);
      wait_done(1);
      lit = '{9'h007, 9'h006, 9'h105};
      chk_beats("stall", lit);
      chk("stall_max_outstanding", max_pend, 2);
      chk("stall_lifo_left", lifo_cnt, 5);
      @(posedge clk); #1;

      // Start pulse during POP is ignored
      start_frame(3);
      start = 1'b1;
      len   = 4'd5;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(1);
      lit = '{9'h004, 9'h003, 9'h102};
      chk_beats("ign", lit);
      chk("ign_lifo_left", lifo_cnt, 2);
      repeat (4) @(posedge clk);
      #1;
      chk("ign_not_queued", int'(busy), 0);

      // Zero-length frame
      re0 = re_cnt;
      v0  = valid_cnt;
      start_frame(0);
      chk("zero_done", int'(done), 1);
      chk("zero_short", int'(short), 0);
      wait_done(0);
      repeat (3) @(posedge clk);
      #1;
      chk("zero_no_re", re_cnt - re0, 0);
      chk("zero_no_valid", valid_cnt - v0, 0);
      chk("zero_lifo_left", lifo_cnt, 2);

      // Reset mid-frame
      for (int i = 0; i < 8; i++) push_val(8'h20 + 8'(i));
      start_frame(8);
      for (int k = 0; k < 50 && got_q.size() < 2; k++) begin
         @(posedge clk); #1;
      end
      chk("mid_two_beats", got_q.size(), 2);
      rst = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      chk("mid_rst_re", int'(lifo_re), 0);
      chk("mid_rst_valid", int'(m_valid), 0);
      chk("mid_rst_data", int'(m_data), 0);
      chk("mid_rst_last", int'(m_last), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_done", int'(done), 0);
      rst = 1'b1;
      v0 = valid_cnt;
      repeat (4) @(posedge clk);
      #1;
      chk("mid_no_stale", valid_cnt - v0, 0);
      cnt0 = lifo_cnt;
      start_frame(2);
      wait_done(0);
      chk("fresh_count", got_q.size(), 2);
      chk("fresh_popped", cnt0 - lifo_cnt, 2);
      chk("fresh_short", int'(short_seen), 0);
      @(posedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
